onehot_req_arbiter: RTL and testbench

ONEHOT_REQ_ARBITER -- requirements
Module: onehot_req_arbiter

---
 rtl/onehot_req_arbiter_pkg.sv | 24 ++
 rtl/onehot_req_arbiter_if.sv | 26 ++
 rtl/onehot_req_arbiter_rr_pick8.sv | 47 ++++
 rtl/onehot_req_arbiter.sv | 103 ++++++++++
 tb/tb_onehot_req_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_req_arbiter_pkg.sv
// Shared definitions for the one-hot request arbiter: default sizes, FSM state
// type and a one-hot to index helper used by the round-robin pointer update.
// Latency: n/a (declarations only). Backpressure: n/a.
package onehot_req_arbiter_pkg;

   localparam int ARB_N     = 8;   // request lines (only 8 supported)
   localparam int ARB_CNT_W = 8;   // drop counter width

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

   // Index of the set bit of an 8-bit one-hot vector (0 when empty).
   function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_req_arbiter_if.sv
// Handshake bundle between the request sources, the arbiter and the encoder.
// Latency: n/a (wires only). Backpressure: grant_ready from the encoder side.
// Ports: req (sources->arb), grant_ready (encoder->arb),
//        grant/grant_valid (arb->encoder), drop_cnt (arb status).
interface onehot_req_arbiter_if #(
   parameter int N     = onehot_req_arbiter_pkg::ARB_N,
   parameter int CNT_W = onehot_req_arbiter_pkg::ARB_CNT_W
);
   logic [N-1:0]     req;
   logic             grant_ready;
   logic [N-1:0]     grant;
   logic             grant_valid;
   logic [CNT_W-1:0] drop_cnt;

   // master: environment driving requests and consuming grants
   modport master (
      output req, grant_ready,
      input  grant, grant_valid, drop_cnt
   );

   // slave: the arbiter itself
   modport slave (
      input  req, grant_ready,
      output grant, grant_valid, drop_cnt
   );
endinterface

// File: rtl/onehot_req_arbiter_rr_pick8.sv
// Combinational selection of one pending bit out of eight, returned one-hot.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: pending_i (candidates), ptr_i (last granted index, RR build only),
//        pick_o (one-hot pick, zero when nothing pending).
// ONEHOT_ARB_RR_EN defined: search upward starting at ptr_i+1 (wrapping);
// undefined: fixed priority, highest index wins, no pointer input.
module rr_pick8 (
   input  logic [7:0] pending_i,
`ifdef ONEHOT_ARB_RR_EN
   input  logic [2:0] ptr_i,
`endif
   output logic [7:0] pick_o
);

`ifdef ONEHOT_ARB_RR_EN
   logic [2:0] idx;
   logic       found;

   // k=8 truncates to ptr_i itself, so the last-granted line is tried last.
   always_comb begin
      pick_o = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= 8; k++) begin
         idx = ptr_i + 3'(k);
         if (!found && pending_i[idx]) begin
            pick_o[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end
`else
   logic found;

   always_comb begin
      pick_o = '0;
      found  = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         if (!found && pending_i[k]) begin
            pick_o[k] = 1'b1;
            found     = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/onehot_req_arbiter.sv
// Turns rising edges on 8 request lines into a registered one-hot grant.
// Latency: edge sampled at clock k -> grant_valid after clock k+1; one bubble
// cycle after each accept. Backpressure: grant held until grant_ready.
// Ports: clk, rst (sync active-high), bus (slave modport: req, grant_ready in;
//        grant, grant_valid, drop_cnt out). Macro: ONEHOT_ARB_RR_EN selects
//        round-robin; default build is fixed priority (highest index wins).
module onehot_req_arbiter #(
   parameter int N     = onehot_req_arbiter_pkg::ARB_N,
   parameter int CNT_W = onehot_req_arbiter_pkg::ARB_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   onehot_req_arbiter_if.slave       bus
);
   import onehot_req_arbiter_pkg::*;

   logic [N-1:0]     req_q;
   logic [N-1:0]     pending_q, pending_d;
   logic [N-1:0]     grant_q;
   logic             grant_valid_q;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   arb_state_e       state_q;

   logic [N-1:0]     edge_v, clear_v, drop_v, pick;
   logic             accept;

`ifdef ONEHOT_ARB_RR_EN
   logic [2:0]       ptr_q;
`endif

   rr_pick8 u_pick (
      .pending_i (pending_q),
`ifdef ONEHOT_ARB_RR_EN
      .ptr_i     (ptr_q),
`endif
      .pick_o    (pick)
   );

   assign accept = (state_q == OFFER) && grant_valid_q && bus.grant_ready;

   // A new edge on a bit being cleared by this accept re-arms it (set wins);
   // an edge on a bit that stays pending is lost and counted.
   always_comb begin
      edge_v     = bus.req & ~req_q;
      clear_v    = accept ? grant_q : '0;
      drop_v     = edge_v & pending_q & ~clear_v;
      pending_d  = (pending_q & ~clear_v) | edge_v;
      drop_cnt_d = drop_cnt_q;
      if ((|drop_v) && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q         <= '0;
         pending_q     <= '0;
         drop_cnt_q    <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         state_q       <= IDLE;
`ifdef ONEHOT_ARB_RR_EN
         ptr_q         <= 3'd7;
`endif
      end else begin
         req_q      <= bus.req;
         pending_q  <= pending_d;
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            IDLE: begin
               if (|pending_q) begin
                  grant_q       <= pick;
                  grant_valid_q <= 1'b1;
                  state_q       <= OFFER;
               end else begin
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
               end
            end
            OFFER: begin
               if (bus.grant_ready) begin
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  state_q       <= IDLE;
`ifdef ONEHOT_ARB_RR_EN
                  ptr_q         <= onehot8_to_idx(grant_q);
`endif
               end
            end
            default: begin
               grant_q       <= '0;
               grant_valid_q <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Self-checking bench for onehot_req_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
// Build with or without ONEHOT_ARB_RR_EN to match the design under test.
module tb_onehot_req_arbiter;

   logic clk = 1'b0;
   logic rst;

   onehot_req_arbiter_if bus_if ();

   onehot_req_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit [7:0] m_req_q;
   bit [7:0] m_pend;
   bit       m_valid;
   int       m_gidx;
   int       m_last;
   int       m_drop;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mdl_reset();
      m_req_q = '0;
      m_pend  = '0;
      m_valid = 1'b0;
      m_gidx  = 0;
      m_last  = 7;
      m_drop  = 0;
   endtask

   // One clock of the arbiter rules, using inputs present before the edge.
   task automatic mdl_step(input logic [7:0] r, input logic rdy);
      bit       accept;
      bit       any_drop;
      bit [7:0] np;
      int       sel;
      accept   = m_valid && rdy;
      any_drop = 1'b0;
      np       = '0;
      for (int i = 0; i < 8; i++) begin
         bit e, clr;
         e   = r[i] && !m_req_q[i];
         clr = accept && (m_gidx == i);
         if (e && m_pend[i] && !clr) any_drop = 1'b1;
         np[i] = e || (m_pend[i] && !clr);
      end
      if (!m_valid) begin
         sel = -1;
`ifdef ONEHOT_ARB_RR_EN
         for (int k = 1; k <= 8; k++)
            if (sel < 0 && m_pend[(m_last + k) % 8]) sel = (m_last + k) % 8;
`else
         for (int k = 7; k >= 0; k--)
            if (sel < 0 && m_pend[k]) sel = k;
`endif
         if (sel >= 0) begin
            m_valid = 1'b1;
            m_gidx  = sel;
         end
      end else if (rdy) begin
         m_valid = 1'b0;
         m_last  = m_gidx;
      end
      if (any_drop && m_drop < 255) m_drop++;
      m_pend  = np;
      m_req_q = r;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus_if.req         = '0;
      bus_if.grant_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      mdl_reset();
   endtask

   task automatic test_reset();
      rst                = 1'b1;
      bus_if.req         = 8'hFF;
      bus_if.grant_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0 || bus_if.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: grant=%b valid=%b drop=%0d, expected 0/0/0",
                  bus_if.grant, bus_if.grant_valid, bus_if.drop_cnt);
      end
      do_reset();
   endtask

   task automatic test_single_pulse();
      do_reset();
      bus_if.grant_ready = 1'b1;
      bus_if.req         = 8'h04;
      tick();
      bus_if.req = 8'h00;
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL pulse_early: grant=%b valid=%b, expected 00000000/0",
                  bus_if.grant, bus_if.grant_valid);
      end
      tick();
      checks++;
      if (bus_if.grant !== 8'h04 || bus_if.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL pulse_offer: grant=%b valid=%b, expected 00000100/1",
                  bus_if.grant, bus_if.grant_valid);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_after%0d: grant=%b valid=%b, expected 00000000/0",
                     i, bus_if.grant, bus_if.grant_valid);
         end
      end
   endtask

   task automatic test_two_requests();
      logic [7:0] first, second;
      logic [7:0] exp [5];
`ifdef ONEHOT_ARB_RR_EN
      first  = 8'b0000_0010;
      second = 8'b0000_0100;
`else
      first  = 8'b0000_0100;
      second = 8'b0000_0010;
`endif
      exp[0] = 8'h00; exp[1] = first; exp[2] = 8'h00; exp[3] = second; exp[4] = 8'h00;
      do_reset();
      bus_if.grant_ready = 1'b1;
      bus_if.req         = 8'b0000_0110;
      for (int c = 0; c < 5; c++) begin
         tick();
         bus_if.req = 8'h00;
         checks++;
         if (bus_if.grant !== exp[c] || bus_if.grant_valid !== (exp[c] != 8'h00)) begin
            errors++;
            $display("FAIL two_req_c%0d: grant=%b valid=%b, expected %b",
                     c, bus_if.grant, bus_if.grant_valid, exp[c]);
         end
      end
   endtask

   task automatic test_hold_backpressure();
      do_reset();
      bus_if.grant_ready = 1'b0;
      bus_if.req         = 8'h01;
      tick();
      bus_if.req = 8'h00;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus_if.grant !== 8'h01 || bus_if.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_c%0d: grant=%b valid=%b, expected 00000001/1",
                     i, bus_if.grant, bus_if.grant_valid);
         end
         tick();
      end
      bus_if.grant_ready = 1'b1;
      checks++;
      if (bus_if.grant !== 8'h01 || bus_if.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_c5: grant=%b valid=%b, expected 00000001/1",
                  bus_if.grant, bus_if.grant_valid);
      end
      tick();
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0 || bus_if.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL hold_accept: grant=%b valid=%b drop=%0d, expected 0/0/0",
                  bus_if.grant, bus_if.grant_valid, bus_if.drop_cnt);
      end
   endtask

   task automatic test_drops();
      do_reset();
      bus_if.grant_ready = 1'b0;
      bus_if.req         = 8'h20;
      tick();
      for (int t = 1; t <= 300; t++) begin
         bus_if.req = 8'h00;
         tick();
         bus_if.req = 8'h20;
         tick();
         if (t == 3 || t == 254) begin
            checks++;
            if (bus_if.drop_cnt !== 8'(t)) begin
               errors++;
               $display("FAIL drop_t%0d: drop=%0d, expected %0d", t, bus_if.drop_cnt, t);
            end
         end
      end
      checks++;
      if (bus_if.drop_cnt !== 8'd255 || bus_if.grant !== 8'h20) begin
         errors++;
         $display("FAIL drop_sat: drop=%0d grant=%b, expected 255/00100000",
                  bus_if.drop_cnt, bus_if.grant);
      end
      bus_if.grant_ready = 1'b1;
      tick();
      tick();
      tick();
      // req[5] held high the whole time: no fresh edge, so no new grant
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL held_no_regrant: grant=%b valid=%b, expected 00000000/0",
                  bus_if.grant, bus_if.grant_valid);
      end
   endtask

   task automatic test_set_wins();
      do_reset();
      bus_if.grant_ready = 1'b0;
      bus_if.req         = 8'h08;
      tick();
      bus_if.req = 8'h00;
      tick();
      bus_if.req         = 8'h08;
      bus_if.grant_ready = 1'b1;
      tick();
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL setwin_accept: grant=%b drop=%0d, expected 00000000/0",
                  bus_if.grant, bus_if.drop_cnt);
      end
      tick();
      checks++;
      if (bus_if.grant !== 8'h08 || bus_if.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL setwin_regrant: grant=%b valid=%b, expected 00001000/1",
                  bus_if.grant, bus_if.grant_valid);
      end
      tick();
      tick();
      checks++;
      if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL setwin_empty: grant=%b valid=%b, expected 00000000/0",
                  bus_if.grant, bus_if.grant_valid);
      end
   endtask

   task automatic test_reset_mid_offer();
      do_reset();
      bus_if.grant_ready = 1'b0;
      bus_if.req         = 8'h80;
      tick();
      tick();
      checks++;
      if (bus_if.grant !== 8'h80) begin
         errors++;
         $display("FAIL rstoffer_pre: grant=%b, expected 10000000", bus_if.grant);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus_if.grant !== 8'h00 || bus_if.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstoffer_in%0d: grant=%b valid=%b, expected 00000000/0",
                     i, bus_if.grant, bus_if.grant_valid);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus_if.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstoffer_post1: valid=%b, expected 0", bus_if.grant_valid);
      end
      tick();
      checks++;
      if (bus_if.grant !== 8'h80 || bus_if.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstoffer_post2: grant=%b valid=%b, expected 10000000/1",
                  bus_if.grant, bus_if.grant_valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       rdy;
      logic [7:0] exp_g;
      do_reset();
      r = '0;
      for (int c = 0; c < 1500; c++) begin
         r   = r ^ 8'($urandom & $urandom);
         rdy = ($urandom_range(0, 3) != 0);
         bus_if.req         = r;
         bus_if.grant_ready = rdy;
         mdl_step(r, rdy);
         tick();
         exp_g = m_valid ? 8'(1 << m_gidx) : 8'h00;
         checks++;
         if (bus_if.grant !== exp_g || bus_if.grant_valid !== m_valid ||
             bus_if.drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL random_c%0d: grant=%b valid=%b drop=%0d, expected %b/%b/%0d",
                     c, bus_if.grant, bus_if.grant_valid, bus_if.drop_cnt,
                     exp_g, m_valid, m_drop);
         end
         checks++;
         if ($countones(bus_if.grant) > 1) begin
            errors++;
            $display("FAIL random_onehot_c%0d: grant=%b, expected at most one bit",
                     c, bus_if.grant);
         end
      end
   endtask

   initial begin
      rst                = 1'b1;
      bus_if.req         = '0;
      bus_if.grant_ready = 1'b0;
      mdl_reset();
      test_reset();
      test_single_pulse();
      test_two_requests();
      test_hold_backpressure();
      test_drops();
      test_set_wins();
      test_reset_mid_offer();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
